seg_display_ctrl: RTL and testbench
===================================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 6, number of 7-segment digits (legal 1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, blink half-period in i_clk cycles (legal >= 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, 1 = segment lit when its bit is 0.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_wr_en, input, 1, write request.
REQ-007 SHALL have port i_rd_en, input, 1, read request.
REQ-008 SHALL have port i_addr, input, 4, register address.
REQ-009 SHALL have port i_wr_data, input, 8, write data.
REQ-010 SHALL have port o_rd_data, output, 8, read data.
REQ-011 SHALL have port o_ack, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port o_err, output, 1, one-cycle invalid-access pulse.
REQ-013 SHALL have port o_seg, output, DIGITS*7, segments; digit d occupies bits [7d+6:7d], bit order g..a (bit 0 = a).

Function
REQ-014 Address map SHALL be: 0..DIGITS-1 DIGIT[d] (bits 6:0 used); 8 MODE; 9 BLANK; 10 BLINK; every other address, including DIGITS..7, is invalid.
REQ-015 MODE/BLANK/BLINK bit d SHALL control digit d; bits >= DIGITS read 0 and ignore writes.
REQ-016 MODE[d]=0 SHALL display DIGIT[d][3:0] as hex 0-F (standard a-g encoding); MODE[d]=1 SHALL drive DIGIT[d][6:0] as raw segments.
REQ-017 A digit SHALL be dark when BLANK[d]=1, or when BLINK[d]=1 and blink phase=1.
REQ-018 Requests sampled at rising edge k SHALL produce o_ack (valid) or o_err (invalid) high for exactly the cycle after edge k; o_rd_data valid in that same cycle, 0 otherwise.
REQ-019 Write accepted at edge k SHALL update the register at edge k; o_seg SHALL reflect it after edge k+1 (o_seg is registered).
REQ-020 Simultaneous i_wr_en and i_rd_en SHALL perform the write only, suppress the read, and pulse o_err instead of o_ack.
REQ-021 Invalid-address access SHALL modify no state and return o_rd_data=0.
REQ-022 Blink counter SHALL count 0..BLINK_DIV-1, wrap to 0, and toggle phase on each wrap.
REQ-023 Any write to BLINK SHALL clear counter and phase to 0 on the same edge.
REQ-024 ACTIVE_LOW=1 SHALL invert every o_seg bit after decode and blanking.
REQ-025 Back-to-back requests on consecutive cycles SHALL all be accepted; no stall, no request queue.

Reset
REQ-026 While i_rst=0, DIGIT=0, MODE=0, BLINK=0, BLANK=all ones for d<DIGITS, counter=0, phase=0, o_ack=0, o_err=0, o_rd_data=0.
REQ-027 While i_rst=0, o_seg SHALL be all dark (all ones when ACTIVE_LOW=1).
REQ-028 Reset asserted mid-blink or mid-request SHALL abandon it; no ack/err pulse follows deassertion.

Structure
REQ-029 Package seg_pkg SHALL hold address constants (ADDR_MODE, ADDR_BLANK, ADDR_BLINK) and the 16-entry hex-to-segment table.
REQ-030 Combinational sub-module hex_to_seg SHALL map 4-bit value to 7-bit active-high segments; seg_display_ctrl instantiates it DIGITS times.

Verification (DIGITS=6, BLINK_DIV=4, ACTIVE_LOW=1)
REQ-031 Reset then release -> o_seg = all 42 ones; read BLANK -> o_rd_data=8'h3F, o_ack one cycle.
REQ-032 Write BLANK=0, DIGIT[0]=8'h0A -> two edges later o_seg[6:0]=7'b0001000 (A); digit 1 shows 0 (7'b1000000).
REQ-033 Write MODE=1, DIGIT[0]=8'h7F -> o_seg[6:0]=7'b0000000; read MODE -> 8'h01.
REQ-034 Write BLINK=8'h02 -> digit 1 dark exactly during cycles 4-7 after the write, lit 0-3 and 8-11; rewrite restarts at lit.
REQ-035 Write addr 7, then simultaneous wr+rd to addr 0 -> o_err pulses both times; addr 7 write changes nothing; addr 0 write takes effect.
REQ-036 Assert i_rst during blink-dark phase -> o_seg immediately all ones, counter/phase 0 after release, no stray o_ack.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display controller: register addresses
// and the hex-to-segment lookup table (active-high, bit order g..a).
package seg_pkg;

  localparam logic [3:0] ADDR_MODE  = 4'd8;
  localparam logic [3:0] ADDR_BLANK = 4'd9;
  localparam logic [3:0] ADDR_BLINK = 4'd10;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit decoder producing active-high segments (bit 0 = a).
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[value];

endmodule

// File: rtl/seg_display_ctrl.sv
// Register-mapped multi-digit 7-segment controller with per-digit hex/raw
// mode, blanking and blinking; segment outputs are registered.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS     = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [3:0]            i_addr,
  input  logic [7:0]            i_wr_data,
  output logic [7:0]            o_rd_data,
  output logic                  o_ack,
  output logic                  o_err,
  output logic [DIGITS*7-1:0]   o_seg
);

  localparam int              CW       = $clog2(BLINK_DIV);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(BLINK_DIV - 1);
  localparam logic [DIGITS*7-1:0] SEG_DARK = {(DIGITS*7){ACTIVE_LOW}};

  logic [6:0]          digit_reg [DIGITS];
  logic [DIGITS-1:0]   mode_reg, blank_reg, blink_reg;
  logic [CW-1:0]       cnt_reg;
  logic                phase_reg;
  logic                ack_reg, err_reg;
  logic [7:0]          rd_data_reg, rd_data_next;
  logic [DIGITS*7-1:0] seg_reg, seg_next;

  logic is_digit, addr_ok, req, wr_ok, rd_ok, bad;
  logic unused_wr_bit;

  assign unused_wr_bit = i_wr_data[7];

  assign is_digit = (i_addr < 4'(DIGITS));
  assign addr_ok  = is_digit || i_addr == ADDR_MODE || i_addr == ADDR_BLANK || i_addr == ADDR_BLINK;
  assign req      = i_wr_en | i_rd_en;
  assign wr_ok    = i_wr_en & addr_ok;
  // A simultaneous write wins; the read is dropped and flagged as an error.
  assign rd_ok    = i_rd_en & ~i_wr_en & addr_ok;
  assign bad      = req & (~addr_ok | (i_wr_en & i_rd_en));

  always_comb begin
    rd_data_next = '0;
    if (rd_ok) begin
      if (is_digit) begin
        for (int i = 0; i < DIGITS; i++)
          if (i_addr == 4'(i)) rd_data_next = {1'b0, digit_reg[i]};
      end else if (i_addr == ADDR_MODE) begin
        rd_data_next = 8'(mode_reg);
      end else if (i_addr == ADDR_BLANK) begin
        rd_data_next = 8'(blank_reg);
      end else begin
        rd_data_next = 8'(blink_reg);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DIGITS; i++) digit_reg[i] <= '0;
      mode_reg    <= '0;
      blank_reg   <= '1;
      blink_reg   <= '0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      ack_reg     <= req & ~bad;
      err_reg     <= bad;
      rd_data_reg <= rd_data_next;
      if (wr_ok) begin
        for (int i = 0; i < DIGITS; i++)
          if (i_addr == 4'(i)) digit_reg[i] <= i_wr_data[6:0];
        if (i_addr == ADDR_MODE)  mode_reg  <= i_wr_data[DIGITS-1:0];
        if (i_addr == ADDR_BLANK) blank_reg <= i_wr_data[DIGITS-1:0];
        if (i_addr == ADDR_BLINK) blink_reg <= i_wr_data[DIGITS-1:0];
      end
    end
  end

  // Blink timebase; restarting on a BLINK write keeps newly blinking digits in phase.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (wr_ok && i_addr == ADDR_BLINK) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_reg   <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      cnt_reg   <= cnt_reg + CW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [6:0] hex_seg, raw_seg;
      logic       dark;

      hex_to_seg u_hex (
        .value (digit_reg[gi][3:0]),
        .seg   (hex_seg)
      );

      assign raw_seg = mode_reg[gi] ? digit_reg[gi] : hex_seg;
      assign dark    = blank_reg[gi] | (blink_reg[gi] & phase_reg);
      assign seg_next[7*gi +: 7] = (dark ? 7'h00 : raw_seg) ^ {7{ACTIVE_LOW}};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) seg_reg <= SEG_DARK;
    else        seg_reg <= seg_next;
  end

  assign o_seg     = seg_reg;
  assign o_ack     = ack_reg;
  assign o_err     = err_reg;
  assign o_rd_data = rd_data_reg;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed testbench for seg_display_ctrl (DIGITS=6, BLINK_DIV=4, ACTIVE_LOW=1).
module tb_seg_display_ctrl;

  logic        clk, rst;
  logic        wr_en, rd_en;
  logic [3:0]  addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        ack, err;
  logic [41:0] seg;

  logic        got_ack, got_err;
  logic [7:0]  got_rd;
  int          n_tests, n_fail;

  seg_display_ctrl #(.DIGITS(6), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (wr_en),
    .i_rd_en   (rd_en),
    .i_addr    (addr),
    .i_wr_data (wr_data),
    .o_rd_data (rd_data),
    .o_ack     (ack),
    .o_err     (err),
    .o_seg     (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus transaction: inputs set at negedge, outputs sampled 1ns after the edge.
  task automatic req(input logic wr, input logic rd, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = wr; rd_en = rd; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    got_ack = ack; got_err = err; got_rd = rd_data;
    wr_en = 1'b0; rd_en = 1'b0;
    $display("[TB] t=%0t wr=%0b rd=%0b addr=%0d data=%h -> ack=%0b err=%0b rd_data=%h",
             $time, wr, rd, a, d, got_ack, got_err, got_rd);
  endtask

  task automatic test_reset;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (seg !== {42{1'b1}}) begin n_fail++; $display("FAIL rst_seg got=%h exp=%h", seg, {42{1'b1}}); end
    n_tests++; if (ack !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_ackerr got=%b%b exp=00", ack, err); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (seg !== {42{1'b1}}) begin n_fail++; $display("FAIL rel_seg got=%h exp=%h", seg, {42{1'b1}}); end
    req(1'b0, 1'b1, 4'd9, 8'h00);
    n_tests++; if (got_rd !== 8'h3F) begin n_fail++; $display("FAIL blank_rd got=%h exp=3f", got_rd); end
    n_tests++; if (got_ack !== 1'b1 || got_err !== 1'b0) begin n_fail++; $display("FAIL blank_ack got=%b%b exp=10", got_ack, got_err); end
    @(posedge clk); #1;
    n_tests++; if (ack !== 1'b0 || rd_data !== 8'h00) begin n_fail++; $display("FAIL ack_once got=%b/%h exp=0/00", ack, rd_data); end
  endtask

  task automatic test_hex;
    req(1'b1, 1'b0, 4'd9, 8'h00);
    req(1'b1, 1'b0, 4'd0, 8'h0A);
    n_tests++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL digit_wr_ack got=%b exp=1", got_ack); end
    @(posedge clk); #1;
    n_tests++; if (seg[6:0] !== 7'b0001000) begin n_fail++; $display("FAIL hex_a got=%b exp=0001000", seg[6:0]); end
    n_tests++; if (seg[13:7] !== 7'b1000000) begin n_fail++; $display("FAIL hex_0 got=%b exp=1000000", seg[13:7]); end
    n_tests++; if (seg[41:14] !== {4{7'b1000000}}) begin n_fail++; $display("FAIL hex_rest got=%h exp=%h", seg[41:14], {4{7'b1000000}}); end
  endtask

  task automatic test_mode;
    req(1'b1, 1'b0, 4'd8, 8'h01);
    req(1'b1, 1'b0, 4'd0, 8'h7F);
    @(posedge clk); #1;
    n_tests++; if (seg[6:0] !== 7'b0000000) begin n_fail++; $display("FAIL raw_seg got=%b exp=0000000", seg[6:0]); end
    req(1'b0, 1'b1, 4'd8, 8'h00);
    n_tests++; if (got_rd !== 8'h01) begin n_fail++; $display("FAIL mode_rd got=%h exp=01", got_rd); end
    req(1'b1, 1'b0, 4'd8, 8'hFF);
    req(1'b0, 1'b1, 4'd8, 8'h00);
    n_tests++; if (got_rd !== 8'h3F) begin n_fail++; $display("FAIL mode_mask got=%h exp=3f", got_rd); end
    req(1'b1, 1'b0, 4'd8, 8'h01);
    req(1'b0, 1'b1, 4'd0, 8'h00);
    n_tests++; if (got_rd !== 8'h7F) begin n_fail++; $display("FAIL digit_rd got=%h exp=7f", got_rd); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    rd_en = 1'b1; addr = 4'd8;
    @(posedge clk); #1;
    n_tests++; if (ack !== 1'b1 || rd_data !== 8'h01) begin n_fail++; $display("FAIL b2b_mode got=%b/%h exp=1/01", ack, rd_data); end
    addr = 4'd9;
    @(posedge clk); #1;
    n_tests++; if (ack !== 1'b1 || rd_data !== 8'h00) begin n_fail++; $display("FAIL b2b_blank got=%b/%h exp=1/00", ack, rd_data); end
    addr = 4'd1;
    @(posedge clk); #1;
    n_tests++; if (ack !== 1'b1 || rd_data !== 8'h00) begin n_fail++; $display("FAIL b2b_digit1 got=%b/%h exp=1/00", ack, rd_data); end
    rd_en = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (ack !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b%b exp=00", ack, err); end
  endtask

  task automatic test_invalid;
    req(1'b1, 1'b0, 4'd7, 8'hFF);
    n_tests++; if (got_err !== 1'b1 || got_ack !== 1'b0) begin n_fail++; $display("FAIL addr7_err got=%b%b exp=01", got_ack, got_err); end
    req(1'b1, 1'b1, 4'd0, 8'h08);
    n_tests++; if (got_err !== 1'b1 || got_ack !== 1'b0 || got_rd !== 8'h00) begin n_fail++; $display("FAIL wrrd_err got=%b%b/%h exp=01/00", got_ack, got_err, got_rd); end
    @(posedge clk); #1;
    n_tests++; if (seg !== {{5{7'h40}}, 7'h77}) begin n_fail++; $display("FAIL wrrd_seg got=%h exp=%h", seg, {{5{7'h40}}, 7'h77}); end
    req(1'b0, 1'b1, 4'd0, 8'h00);
    n_tests++; if (got_rd !== 8'h08 || got_ack !== 1'b1) begin n_fail++; $display("FAIL wrrd_rd got=%h/%b exp=08/1", got_rd, got_ack); end
    req(1'b0, 1'b1, 4'd6, 8'h00);
    n_tests++; if (got_err !== 1'b1 || got_rd !== 8'h00) begin n_fail++; $display("FAIL addr6_err got=%b/%h exp=1/00", got_err, got_rd); end
    req(1'b0, 1'b1, 4'd15, 8'h00);
    n_tests++; if (got_err !== 1'b1 || got_ack !== 1'b0 || got_rd !== 8'h00) begin n_fail++; $display("FAIL addr15_err got=%b%b/%h exp=01/00", got_ack, got_err, got_rd); end
  endtask

  task automatic test_blink;
    logic [6:0] exp_seg;
    req(1'b1, 1'b0, 4'd10, 8'h02);
    n_tests++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL blink_ack got=%b exp=1", got_ack); end
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      exp_seg = (n >= 4 && n < 8) ? 7'h7F : 7'h40;
      n_tests++; if (seg[13:7] !== exp_seg) begin n_fail++; $display("FAIL blink_c%0d got=%b exp=%b", n, seg[13:7], exp_seg); end
    end
    n_tests++; if (seg[6:0] !== 7'h77) begin n_fail++; $display("FAIL blink_d0 got=%b exp=1110111", seg[6:0]); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (seg[13:7] !== 7'h7F) begin n_fail++; $display("FAIL blink_dark got=%b exp=1111111", seg[13:7]); end
    req(1'b1, 1'b0, 4'd10, 8'h02);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      exp_seg = (n == 4) ? 7'h7F : 7'h40;
      n_tests++; if (seg[13:7] !== exp_seg) begin n_fail++; $display("FAIL restart_c%0d got=%b exp=%b", n, seg[13:7], exp_seg); end
    end
  endtask

  task automatic test_reset_mid;
    n_tests++; if (seg[13:7] !== 7'h7F) begin n_fail++; $display("FAIL pre_rst_dark got=%b exp=1111111", seg[13:7]); end
    #1;
    rst = 1'b0; rd_en = 1'b1; addr = 4'd9;
    #1;
    n_tests++; if (seg !== {42{1'b1}}) begin n_fail++; $display("FAIL mid_rst_seg got=%h exp=%h", seg, {42{1'b1}}); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (ack !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ack got=%b%b exp=00", ack, err); end
    @(negedge clk);
    rst = 1'b1; rd_en = 1'b0;
    #1;
    n_tests++; if (dut.cnt_reg !== 2'd0 || dut.phase_reg !== 1'b0) begin n_fail++; $display("FAIL rel_cnt got=%0d/%b exp=0/0", dut.cnt_reg, dut.phase_reg); end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      n_tests++; if (ack !== 1'b0 || err !== 1'b0 || seg !== {42{1'b1}}) begin n_fail++; $display("FAIL post_rst_c%0d got=%b%b/%h", n, ack, err, seg); end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    got_ack = 1'b0; got_err = 1'b0; got_rd = '0;
    test_reset;
    test_hex;
    test_mode;
    test_back_to_back;
    test_invalid;
    test_blink;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
